rule_scan_ctrl: RTL and testbench

Linear-scan classification controller. Accepts one packet_s per transaction, walks the rule table (rule_s entries in an external synchronous-read memory) from index 0 upward, and returns the lowest-index rule whose every field range contains the packet. Sits between the packet ingress and the rule-table RAM. It is the sequencer that owns that RAM's read port.

---
 rtl/rule_scan_ctrl_pkg.sv | 55 +++++
 rtl/rule_scan_ctrl_rule_match.sv | 20 ++
 rtl/rule_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_rule_scan_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule_scan_ctrl_pkg.sv
// Shared types for the rule-scan classifier: packet/rule layouts, result record
// and the unsigned range test every classifier flavour uses.
package rule_scan_ctrl_pkg;

  localparam int MAX_RULES = 64;

  typedef logic [$clog2(MAX_RULES)-1:0] rule_idx_t;

  typedef struct packed {
    logic      match;
    rule_idx_t idx;
  } result_s;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
  } endpoint_s;

  typedef struct packed {
    endpoint_s   src;
    endpoint_s   dst;
    logic [7:0]  protocol;
  } packet_s;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] last;
  } ip_range_s;

  typedef struct packed {
    logic [15:0] start;
    logic [15:0] last;
  } port_range_s;

  typedef struct packed {
    logic [7:0] start;
    logic [7:0] last;
  } proto_range_s;

  typedef struct packed {
    ip_range_s    src_ip;
    port_range_s  src_port;
    ip_range_s    dst_ip;
    port_range_s  dst_port;
    proto_range_s protocol;
  } rule_s;

  // An inverted range (lo > hi) can never contain a value.
  function automatic logic in_range(input logic [31:0] value,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/rule_scan_ctrl_rule_match.sv
// Combinational single-rule matcher: hit when every packet field lies inside
// the rule's inclusive range.
module rule_match
  import rule_scan_ctrl_pkg::*;
(
  input  packet_s pkt_i,
  input  rule_s   rule_i,
  output logic    hit_o
);

  assign hit_o = in_range(pkt_i.src.ip, rule_i.src_ip.start, rule_i.src_ip.last)
              && in_range(32'(pkt_i.src.port), 32'(rule_i.src_port.start),
                          32'(rule_i.src_port.last))
              && in_range(pkt_i.dst.ip, rule_i.dst_ip.start, rule_i.dst_ip.last)
              && in_range(32'(pkt_i.dst.port), 32'(rule_i.dst_port.start),
                          32'(rule_i.dst_port.last))
              && in_range(32'(pkt_i.protocol), 32'(rule_i.protocol.start),
                          32'(rule_i.protocol.last));

endmodule

// File: rtl/rule_scan_ctrl.sv
// Linear-scan classifier: walks the external rule RAM from index 0 and reports
// the lowest-index rule containing the latched packet.
module rule_scan_ctrl
  import rule_scan_ctrl_pkg::*;
#(
  parameter int NUM_RULES = 64,
  parameter int IDX_W     = $clog2(NUM_RULES),
  parameter int CNT_W     = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             pkt_valid_in,
  output logic             pkt_ready_out,
  input  packet_s          pkt_in,
  input  logic [IDX_W:0]   num_rules_in,
  output logic             rule_rd_en_out,
  output logic [IDX_W-1:0] rule_addr_out,
  input  rule_s            rule_in,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic             match_out,
  output logic [IDX_W-1:0] match_idx_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] pkt_count_out,
  output logic [CNT_W-1:0] hit_count_out
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [IDX_W:0] NUM_RULES_W = (IDX_W+1)'(NUM_RULES);

  state_e           state_q;
  packet_s          pkt_q;
  logic [IDX_W:0]   n_q;
  logic             rd_en_q;
  logic [IDX_W-1:0] addr_q;
  logic             cmp_valid_q;
  logic [IDX_W-1:0] cmp_idx_q;
  result_s          result_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] hit_cnt_q;

  logic             rule_hit;
  logic [IDX_W:0]   n_clamped;
  logic [IDX_W:0]   addr_next;
  logic             cmp_last;

  rule_match u_rule_match (
    .pkt_i  (pkt_q),
    .rule_i (rule_in),
    .hit_o  (rule_hit)
  );

  assign n_clamped = (num_rules_in > NUM_RULES_W) ? NUM_RULES_W : num_rules_in;
  assign addr_next = {1'b0, addr_q} + (IDX_W+1)'(1);
  assign cmp_last  = ({1'b0, cmp_idx_q} == (n_q - (IDX_W+1)'(1)));

  // cmp_valid_q/cmp_idx_q trail the read strobe by one cycle, lining up with
  // the RAM's registered data; reads in flight past a hit are simply dropped.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      n_q         <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_idx_q   <= '0;
      result_q    <= '0;
      pkt_cnt_q   <= '0;
      hit_cnt_q   <= '0;
    end else begin
      cmp_valid_q <= rd_en_q;
      cmp_idx_q   <= addr_q;
      case (state_q)
        IDLE: begin
          if (pkt_valid_in) begin
            pkt_q    <= pkt_in;
            n_q      <= n_clamped;
            addr_q   <= '0;
            result_q <= '0;
            if (n_clamped == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= SCAN;
              rd_en_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (rd_en_q) begin
            if (addr_next < n_q) addr_q <= addr_q + IDX_W'(1);
            else                 rd_en_q <= 1'b0;
          end
          if (cmp_valid_q && rule_hit) begin
            state_q      <= DONE;
            rd_en_q      <= 1'b0;
            cmp_valid_q  <= 1'b0;
            result_q.match <= 1'b1;
            result_q.idx   <= rule_idx_t'(cmp_idx_q);
          end else if (cmp_valid_q && cmp_last) begin
            state_q     <= DONE;
            rd_en_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            result_q    <= '0;
          end
        end
        DONE: begin
          if (result_ready_in) begin
            state_q   <= IDLE;
            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            hit_cnt_q <= hit_cnt_q + CNT_W'(result_q.match);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt_ready_out    = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign result_valid_out = (state_q == DONE);
  assign match_out        = result_q.match;
  assign match_idx_out    = IDX_W'(result_q.idx);
  assign rule_rd_en_out   = rd_en_q;
  assign rule_addr_out    = addr_q;
  assign pkt_count_out    = pkt_cnt_q;
  assign hit_count_out    = hit_cnt_q;

endmodule

// File: tb/tb_rule_scan_ctrl.sv
// Self-checking bench for rule_scan_ctrl: behavioural first-match model over a
// bench-owned rule RAM, directed corner cases plus randomized traffic.
module tb_rule_scan_ctrl;
  import rule_scan_ctrl_pkg::*;

  localparam int NR = 64;
  localparam int IW = 6;
  localparam int CW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          pkt_valid_in = 1'b0;
  logic          pkt_ready_out;
  packet_s       pkt_in = '0;
  logic [IW:0]   num_rules_in = '0;
  logic          rule_rd_en_out;
  logic [IW-1:0] rule_addr_out;
  rule_s         rule_in = '0;
  logic          result_valid_out;
  logic          result_ready_in = 1'b0;
  logic          match_out;
  logic [IW-1:0] match_idx_out;
  logic          busy_out;
  logic [CW-1:0] pkt_count_out;
  logic [CW-1:0] hit_count_out;

  rule_scan_ctrl #(.NUM_RULES(NR), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pkt_valid_in     (pkt_valid_in),
    .pkt_ready_out    (pkt_ready_out),
    .pkt_in           (pkt_in),
    .num_rules_in     (num_rules_in),
    .rule_rd_en_out   (rule_rd_en_out),
    .rule_addr_out    (rule_addr_out),
    .rule_in          (rule_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .match_out        (match_out),
    .match_idx_out    (match_idx_out),
    .busy_out         (busy_out),
    .pkt_count_out    (pkt_count_out),
    .hit_count_out    (hit_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read rule RAM owned by the bench.
  rule_s mem [NR];
  always @(posedge clk_in) if (rule_rd_en_out) rule_in <= mem[rule_addr_out];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model state shared with the per-cycle compare process.
  bit   mon_en = 1'b0;
  logic exp_match = 1'b0;
  int   exp_idx = 0;
  int   exp_n = 0;
  int   rd_count = 0;
  int   rd_max = -1;
  int   m_pkt = 0;
  int   m_hit = 0;

  function automatic bit inr(input logic [31:0] v, input logic [31:0] s, input logic [31:0] l);
    return (v >= s) && (v <= l);
  endfunction

  function automatic bit rule_hits(input packet_s p, input rule_s r);
    return inr(p.src.ip, r.src_ip.start, r.src_ip.last)
        && inr(32'(p.src.port), 32'(r.src_port.start), 32'(r.src_port.last))
        && inr(p.dst.ip, r.dst_ip.start, r.dst_ip.last)
        && inr(32'(p.dst.port), 32'(r.dst_port.start), 32'(r.dst_port.last))
        && inr(32'(p.protocol), 32'(r.protocol.start), 32'(r.protocol.last));
  endfunction

  function automatic int first_hit(input packet_s p, input int n);
    for (int i = 0; i < n; i++) if (rule_hits(p, mem[i])) return i;
    return -1;
  endfunction

  function automatic rule_s full_rule();
    rule_s r;
    r.src_ip.start   = '0; r.src_ip.last   = '1;
    r.src_port.start = '0; r.src_port.last = '1;
    r.dst_ip.start   = '0; r.dst_ip.last   = '1;
    r.dst_port.start = '0; r.dst_port.last = '1;
    r.protocol.start = '0; r.protocol.last = '1;
    return r;
  endfunction

  function automatic packet_s mk_pkt(input logic [31:0] sip, input logic [15:0] sp,
                                     input logic [31:0] dip, input logic [15:0] dp,
                                     input logic [7:0] pr);
    packet_s p;
    p.src.ip = sip; p.src.port = sp; p.dst.ip = dip; p.dst.port = dp; p.protocol = pr;
    return p;
  endfunction

  function automatic packet_s rand_pkt();
    return mk_pkt(32'h0A00_0000 + $urandom_range(0, 15), 16'($urandom_range(0, 15)),
                  32'h0A00_0000 + $urandom_range(0, 15), 16'($urandom_range(0, 15)),
                  8'($urandom_range(0, 15)));
  endfunction

  // Returns {start,last}: full range, a small window, or an inverted window.
  function automatic logic [63:0] rand_rng(input logic [31:0] base, input logic [31:0] full_last);
    int sel;
    logic [31:0] v;
    sel = $urandom_range(0, 3);
    v = base + $urandom_range(0, 8);
    case (sel)
      0, 1:    return {32'h0, full_last};
      2:       return {v, v + $urandom_range(0, 8)};
      default: return {v + $urandom_range(1, 4), v};
    endcase
  endfunction

  function automatic rule_s rand_rule();
    rule_s r;
    logic [63:0] x;
    x = rand_rng(32'h0A00_0000, 32'hFFFF_FFFF); r.src_ip.start = x[63:32]; r.src_ip.last = x[31:0];
    x = rand_rng(32'h0, 32'hFFFF); r.src_port.start = x[47:32]; r.src_port.last = x[15:0];
    x = rand_rng(32'h0A00_0000, 32'hFFFF_FFFF); r.dst_ip.start = x[63:32]; r.dst_ip.last = x[31:0];
    x = rand_rng(32'h0, 32'hFFFF); r.dst_port.start = x[47:32]; r.dst_port.last = x[15:0];
    x = rand_rng(32'h0, 32'hFF); r.protocol.start = x[39:32]; r.protocol.last = x[7:0];
    return r;
  endfunction

  // Per-cycle compare against the model while outputs are meaningful.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (result_valid_out) begin
        checkOutput("result_match", match_out, exp_match);
        checkOutput("result_idx", match_idx_out, exp_idx);
      end
      if (rule_rd_en_out) begin
        rd_count++;
        if (int'(rule_addr_out) > rd_max) rd_max = int'(rule_addr_out);
        checkOutput("rd_addr_below_n", int'(rule_addr_out) < exp_n, 1);
      end
      checkOutput("pkt_count", pkt_count_out, m_pkt);
      checkOutput("hit_count", hit_count_out, m_hit);
    end
  end

  // Called #1 after a clock edge with the DUT idle; drives immediately so
  // back-to-back calls exercise acceptance on the cycle after a handshake.
  task automatic applyStimulus(input packet_s p, input int nraw, input int hold,
                               output int g_match, output int g_idx, output int g_lat,
                               output int g_reads, output int g_max);
    int n, k, lat, exp_lat, exp_reads;
    n = (nraw > NR) ? NR : nraw;
    k = first_hit(p, n);
    exp_match = (k >= 0);
    exp_idx   = (k >= 0) ? k : 0;
    exp_n     = n;
    if (n == 0)      begin exp_lat = 1;     exp_reads = 0; end
    else if (k >= 0) begin exp_lat = k + 3; exp_reads = (k + 2 < n) ? k + 2 : n; end
    else             begin exp_lat = n + 2; exp_reads = n; end
    checkOutput("ready_before_send", pkt_ready_out, 1);
    rd_count = 0;
    rd_max = -1;
    pkt_in = p;
    num_rules_in = (IW+1)'(nraw);
    pkt_valid_in = 1'b1;
    @(posedge clk_in); #1;
    lat = 1;
    pkt_valid_in = 1'b0;
    pkt_in = rand_pkt();
    num_rules_in = (IW+1)'($urandom_range(0, 127));
    while (!result_valid_out && lat < 200) begin
      @(posedge clk_in); #1;
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    g_match = int'(match_out);
    g_idx = int'(match_idx_out);
    g_lat = lat;
    for (int h = 0; h < hold; h++) begin
      pkt_valid_in = 1'b1;
      pkt_in = rand_pkt();
      @(posedge clk_in); #1;
      checkOutput("held_valid", result_valid_out, 1);
      checkOutput("held_not_ready", pkt_ready_out, 0);
    end
    pkt_valid_in = 1'b0;
    result_ready_in = 1'b1;
    @(posedge clk_in); #1;
    result_ready_in = 1'b0;
    m_pkt++;
    m_hit += int'(exp_match);
    checkOutput("read_count", rd_count, exp_reads);
    checkOutput("idle_after_handshake", pkt_ready_out, 1);
    g_reads = rd_count;
    g_max = rd_max;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    packet_s p;
    rule_s r;
    int gm, gi, gl, gr, gx, base_pkt, base_hit, cnt;

    for (int i = 0; i < NR; i++) mem[i] = full_rule();

    // Reset state
    #12;
    checkOutput("reset_ready", pkt_ready_out, 1);
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_valid", result_valid_out, 0);
    checkOutput("reset_rd_en", rule_rd_en_out, 0);
    checkOutput("reset_pkt_count", pkt_count_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_in); #1;

    // Hit at rule 0 on a /24 source window
    r = full_rule(); r.src_ip.start = 32'h0A00_0000; r.src_ip.last = 32'h0A00_00FF;
    mem[0] = r;
    p = mk_pkt(32'h0A00_0005, 16'd1234, 32'hC0A8_0001, 16'd80, 8'd17);
    applyStimulus(p, 4, 0, gm, gi, gl, gr, gx);
    checkOutput("t1_match", gm, 1);
    checkOutput("t1_idx", gi, 0);
    checkOutput("t1_lat", gl, 3);
    checkOutput("t1_reads", gr, 2);

    // Only rule 5 matches on protocol 6..6
    for (int i = 0; i < NR; i++) begin
      r = full_rule(); r.protocol.start = 8'd7; r.protocol.last = 8'd7; mem[i] = r;
    end
    r = full_rule(); r.protocol.start = 8'd6; r.protocol.last = 8'd6; mem[5] = r;
    p = mk_pkt(32'h0A00_0001, 16'd1, 32'h0A00_0002, 16'd2, 8'd6);
    applyStimulus(p, 8, 0, gm, gi, gl, gr, gx);
    checkOutput("t2_idx", gi, 5);
    checkOutput("t2_lat", gl, 8);
    checkOutput("t2_max_addr", gx, 6);

    // Rules 2 and 6 both match: lowest index wins
    mem[5].protocol.start = 8'd7; mem[5].protocol.last = 8'd7;
    mem[2].protocol.start = 8'd6; mem[2].protocol.last = 8'd6;
    mem[6].protocol.start = 8'd6; mem[6].protocol.last = 8'd6;
    applyStimulus(p, 8, 0, gm, gi, gl, gr, gx);
    checkOutput("t3_idx", gi, 2);

    // Full miss: all rules dst.port 443..443, packet port 80
    for (int i = 0; i < NR; i++) begin
      r = full_rule(); r.dst_port.start = 16'd443; r.dst_port.last = 16'd443; mem[i] = r;
    end
    p = mk_pkt(32'h0A00_0001, 16'd1, 32'h0A00_0002, 16'd80, 8'd6);
    applyStimulus(p, 8, 0, gm, gi, gl, gr, gx);
    checkOutput("t4_match", gm, 0);
    checkOutput("t4_idx", gi, 0);
    checkOutput("t4_lat", gl, 10);
    checkOutput("t4_reads", gr, 8);

    // Empty table
    applyStimulus(p, 0, 0, gm, gi, gl, gr, gx);
    checkOutput("t5_lat", gl, 1);
    checkOutput("t5_reads", gr, 0);

    // Clamp 100 -> 64; rule 62 has an inverted range, rule 63 matches
    r = full_rule(); r.src_port.start = 16'd10; r.src_port.last = 16'd5; mem[62] = r;
    mem[63] = full_rule();
    applyStimulus(p, 100, 0, gm, gi, gl, gr, gx);
    checkOutput("t6_idx", gi, 63);
    checkOutput("t6_lat", gl, 66);
    checkOutput("t6_max_addr", gx, 63);

    // Held result, then three back-to-back packets with two hits
    base_pkt = m_pkt;
    base_hit = m_hit;
    applyStimulus(p, 8, 5, gm, gi, gl, gr, gx);
    mem[1] = full_rule();
    applyStimulus(p, 8, 0, gm, gi, gl, gr, gx);
    applyStimulus(p, 4, 0, gm, gi, gl, gr, gx);
    checkOutput("b2b_idx", gi, 1);
    checkOutput("b2b_pkt_delta", pkt_count_out - CW'(base_pkt), 3);
    checkOutput("b2b_hit_delta", hit_count_out - CW'(base_hit), 2);

    // Asynchronous reset in the middle of a scan
    for (int i = 0; i < NR; i++) begin
      r = full_rule(); r.dst_port.start = 16'd443; r.dst_port.last = 16'd443; mem[i] = r;
    end
    exp_n = 8;
    pkt_in = p;
    num_rules_in = 7'd8;
    pkt_valid_in = 1'b1;
    @(posedge clk_in); #1;
    pkt_valid_in = 1'b0;
    cnt = 0;
    while (!(rule_rd_en_out && rule_addr_out == 6'd3) && cnt < 20) begin
      @(posedge clk_in); #1;
      cnt++;
    end
    checkOutput("rst_reach_addr3", rule_addr_out, 3);
    #2;
    rst_in = 1'b1;
    mon_en = 1'b0;
    #1;
    checkOutput("rst_rd_en", rule_rd_en_out, 0);
    checkOutput("rst_valid", result_valid_out, 0);
    checkOutput("rst_ready", pkt_ready_out, 1);
    checkOutput("rst_busy", busy_out, 0);
    checkOutput("rst_pkt_count", pkt_count_out, 0);
    checkOutput("rst_hit_count", hit_count_out, 0);
    m_pkt = 0;
    m_hit = 0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_in); #1;
    mem[1] = full_rule();
    applyStimulus(p, 8, 0, gm, gi, gl, gr, gx);
    checkOutput("post_rst_idx", gi, 1);
    checkOutput("post_rst_lat", gl, 4);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      int nraw, sel;
      for (int i = 0; i < NR; i++) mem[i] = rand_rule();
      sel = $urandom_range(0, 9);
      if (sel == 0)      nraw = 0;
      else if (sel == 1) nraw = $urandom_range(65, 127);
      else               nraw = $urandom_range(1, 20);
      applyStimulus(rand_pkt(), nraw, $urandom_range(0, 2), gm, gi, gl, gr, gx);
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
